// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - transaction codes, scheduler state enum and pend-bit indices for the SB scheduler
package sb_pkg;

  localparam logic [2:0] TRANS_NONE   = 3'd0;
  localparam logic [2:0] TRANS_AT_CMD = 3'd2;
  localparam logic [2:0] TRANS_AT_RSP = 3'd3;
  localparam logic [2:0] TRANS_LT     = 3'd4;

  localparam logic [1:0] PEND_AT_CMD = 2'd0;
  localparam logic [1:0] PEND_AT_RSP = 2'd1;
  localparam logic [1:0] PEND_LT     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SENT,
    S_GAP
  } sched_state_t;

  function automatic logic [2:0] pend_code(input logic [1:0] idx);
    case (idx)
      PEND_LT:     return TRANS_LT;
      PEND_AT_RSP: return TRANS_AT_RSP;
      default:     return TRANS_AT_CMD;
    endcase
  endfunction

endpackage

// File: rtl/sb_rsp_timer.sv
// rtl/sb_rsp_timer.sv - outstanding AT command flag and response timeout; retry counter under SB_SCHED_RETRY_EN
// done/retry/err are single-cycle event strobes; the scheduler registers them.
module sb_rsp_timer #(
  parameter int RSP_TIMEOUT = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rsp,
  input  logic clear,
  output logic outstanding,
  output logic done,
  output logic retry,
  output logic err
);

  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  logic [TW-1:0] cnt;
  logic          expire;

  // A response arriving in the expiry cycle takes precedence over the timeout.
  assign done   = outstanding && !clear && rsp;
  assign expire = outstanding && !clear && !rsp && (cnt <= TW'(1));

`ifdef SB_SCHED_RETRY_EN
  logic [7:0] retry_cnt;

  assign retry = expire && (retry_cnt < 8'(MAX_RETRY));
  assign err   = expire && !retry;

  always_ff @(posedge clk) begin
    if (rst || clear || done || err) begin
      retry_cnt <= '0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end
`else
  logic unused_max_retry;

  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry = 1'b0;
  assign err   = expire;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      outstanding <= 1'b0;
      cnt         <= '0;
    end else if (start) begin
      outstanding <= 1'b1;
      cnt         <= TW'(RSP_TIMEOUT);
    end else if (done || expire) begin
      outstanding <= 1'b0;
      cnt         <= '0;
    end else if (outstanding) begin
      cnt <= cnt - TW'(1);
    end
  end

endmodule

// File: rtl/sb_trans_scheduler.sv
// rtl/sb_trans_scheduler.sv - fixed-priority SB transaction scheduler (LT > AT_RSP > AT_CMD)
// AT command retry on response timeout is enabled by SB_SCHED_RETRY_EN.
module sb_trans_scheduler
  import sb_pkg::*;
#(
  parameter int RSP_TIMEOUT = 4096,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic       at_rsp_req,
  input  logic       at_cmd_req,
  input  logic       at_rsp_rcvd,
  input  logic       trans_sent,
  input  logic       disconnected_s,
  output logic [2:0] trans_sel,
  output logic       lt_done,
  output logic       at_rsp_done,
  output logic       at_cmd_done,
  output logic       at_cmd_err,
  output logic [2:0] pend,
  output logic       busy
);

  sched_state_t state, state_n;
  logic [1:0]   cur, cur_n;
  logic [7:0]   gap_cnt, gap_n;
  logic [2:0]   reqs, avail, pend_n, sel_n;
  logic         lt_done_n, rsp_done_n, tmr_start;
  logic         outstanding, tmr_done, tmr_retry, tmr_err;

  assign reqs  = {lt_req, at_rsp_req, at_cmd_req};
  // Requests arriving this cycle are eligible immediately; AT_CMD waits while one is outstanding.
  assign avail = (pend | reqs) & {2'b11, !outstanding};
  assign busy  = (state != S_IDLE) || outstanding;

  sb_rsp_timer #(
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) u_rsp_timer (
    .clk        (sb_clk),
    .rst        (rst),
    .start      (tmr_start),
    .rsp        (at_rsp_rcvd),
    .clear      (disconnected_s),
    .outstanding(outstanding),
    .done       (tmr_done),
    .retry      (tmr_retry),
    .err        (tmr_err)
  );

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    gap_n      = gap_cnt;
    pend_n     = pend | reqs;
    sel_n      = TRANS_NONE;
    lt_done_n  = 1'b0;
    rsp_done_n = 1'b0;
    tmr_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!disconnected_s && (avail != 3'b000)) begin
          state_n = S_ISSUE;
          if (avail[PEND_LT])          cur_n = PEND_LT;
          else if (avail[PEND_AT_RSP]) cur_n = PEND_AT_RSP;
          else                         cur_n = PEND_AT_CMD;
        end
      end
      S_ISSUE: begin
        if (disconnected_s) begin
          state_n = S_IDLE;
        end else begin
          sel_n        = pend_code(cur);
          pend_n[cur]  = reqs[cur];
          state_n      = S_WAIT_SENT;
        end
      end
      S_WAIT_SENT: begin
        if (disconnected_s) begin
          pend_n[cur] = 1'b1;
          state_n     = S_IDLE;
        end else if (trans_sent) begin
          lt_done_n  = (cur == PEND_LT);
          rsp_done_n = (cur == PEND_AT_RSP);
          tmr_start  = (cur == PEND_AT_CMD);
          gap_n      = '0;
          state_n    = S_GAP;
        end
      end
      S_GAP: begin
        if (disconnected_s) begin
          pend_n[cur] = 1'b1;
          state_n     = S_IDLE;
        end else if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
          state_n = S_IDLE;
        end else begin
          gap_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A retried or disconnect-abandoned command goes back into the queue.
    if (tmr_retry || (disconnected_s && outstanding)) begin
      pend_n[PEND_AT_CMD] = 1'b1;
    end
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cur         <= PEND_AT_CMD;
      gap_cnt     <= '0;
      pend        <= '0;
      trans_sel   <= TRANS_NONE;
      lt_done     <= 1'b0;
      at_rsp_done <= 1'b0;
      at_cmd_done <= 1'b0;
      at_cmd_err  <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      gap_cnt     <= gap_n;
      pend        <= pend_n;
      trans_sel   <= sel_n;
      lt_done     <= lt_done_n;
      at_rsp_done <= rsp_done_n;
      at_cmd_done <= tmr_done;
      at_cmd_err  <= tmr_err;
    end
  end

endmodule

// File: tb/tb_sb_trans_scheduler.sv
// tb/tb_sb_trans_scheduler.sv - self-checking bench for sb_trans_scheduler (honours SB_SCHED_RETRY_EN)
module tb_sb_trans_scheduler;

  localparam int T   = 16;
  localparam int MR  = 2;
  localparam int GAP = 2;
`ifdef SB_SCHED_RETRY_EN
  localparam bit RETRY_EN   = 1'b1;
  localparam int CMD_ISSUES = MR + 1;
`else
  localparam bit RETRY_EN   = 1'b0;
  localparam int CMD_ISSUES = 1;
`endif

  logic sb_clk = 1'b0;
  logic rst = 1'b1;
  logic lt_req = 1'b0, at_rsp_req = 1'b0, at_cmd_req = 1'b0;
  logic at_rsp_rcvd = 1'b0, trans_sent = 1'b0, disconnected_s = 1'b0;
  logic [2:0] trans_sel, pend;
  logic lt_done, at_rsp_done, at_cmd_done, at_cmd_err, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sb_trans_scheduler #(
    .RSP_TIMEOUT(T),
    .MAX_RETRY  (MR),
    .GAP_CYCLES (GAP)
  ) dut (
    .sb_clk        (sb_clk),
    .rst           (rst),
    .lt_req        (lt_req),
    .at_rsp_req    (at_rsp_req),
    .at_cmd_req    (at_cmd_req),
    .at_rsp_rcvd   (at_rsp_rcvd),
    .trans_sent    (trans_sent),
    .disconnected_s(disconnected_s),
    .trans_sel     (trans_sel),
    .lt_done       (lt_done),
    .at_rsp_done   (at_rsp_done),
    .at_cmd_done   (at_cmd_done),
    .at_cmd_err    (at_cmd_err),
    .pend          (pend),
    .busy          (busy)
  );

  always #5 sb_clk = ~sb_clk;
  always @(posedge sb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int code2bit(input logic [2:0] code);
    return (code == 3'd4) ? 2 : (code == 3'd3) ? 1 : 0;
  endfunction

  // Reference model: pending set, in-flight transaction and outstanding command, by event time.
  logic [2:0] m_pend;
  logic       m_out, m_wait;
  logic [2:0] m_code;
  int         m_deadline, m_retry, last_sent, last_issue;
  logic       p_rst = 1'b0, p_lt = 1'b0, p_rsp = 1'b0, p_cmd = 1'b0;
  logic       p_rcvd = 1'b0, p_sent = 1'b0, p_disc = 1'b0;
  bit         started = 1'b0;
  int         n_sel2 = 0, n_err = 0, err_at = -1, n_lt_done = 0, n_cmd_done = 0;

  always @(negedge sb_clk) begin
    logic       e_lt, e_rsp, e_cdone, e_err, expire;
    logic [2:0] e_pend, issuable, preq;
    int         c, top;
    c    = cyc;
    preq = {p_lt, p_rsp, p_cmd};
    if (p_rst) begin
      m_pend = '0; m_out = 1'b0; m_wait = 1'b0; m_code = '0; m_retry = 0; m_deadline = -1;
      last_sent = -100; last_issue = -100; started = 1'b1;
      chk("rst_trans_sel", trans_sel, 0);
      chk("rst_pend", pend, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dones", {lt_done, at_rsp_done, at_cmd_done}, 0);
      chk("rst_err", at_cmd_err, 0);
    end else if (started) begin
      e_lt    = p_sent && !p_disc && m_wait && (m_code == 3'd4);
      e_rsp   = p_sent && !p_disc && m_wait && (m_code == 3'd3);
      e_cdone = p_rcvd && m_out && !p_disc;
      expire  = m_out && !p_rcvd && !p_disc && (c - 1 == m_deadline);
      e_err   = expire && (!RETRY_EN || m_retry >= MR);
      e_pend  = m_pend | preq;
      if ((expire && !e_err) || (p_disc && m_out)) e_pend[0] = 1'b1;
      if (p_disc && m_wait) e_pend[code2bit(m_code)] = 1'b1;

      issuable = m_pend & {2'b11, !m_out};
      top = issuable[2] ? 4 : issuable[1] ? 3 : issuable[0] ? 2 : 0;
      if (trans_sel != 3'd0) begin
        chk("issue_priority_code", trans_sel, top);
        chk("issue_back_to_back", (last_issue == c - 1), 0);
        chk("issue_gap_after_sent", (c >= last_sent + 2 + GAP), 1);
        chk("issue_while_in_flight", m_wait, 0);
        chk("issue_while_disconnected", p_disc, 0);
      end

      if (p_disc) begin
        m_out = 1'b0; m_retry = 0;
      end else if (p_sent && m_wait && (m_code == 3'd2)) begin
        m_out = 1'b1; m_deadline = c - 1 + T;
      end else if (e_cdone) begin
        m_out = 1'b0; m_retry = 0;
      end else if (expire) begin
        m_out = 1'b0; m_retry = e_err ? 0 : m_retry + 1;
      end
      if (p_disc) begin
        m_wait = 1'b0;
      end else if (p_sent && m_wait) begin
        m_wait = 1'b0; last_sent = c - 1;
      end

      if (trans_sel != 3'd0) begin
        e_pend[code2bit(trans_sel)] = preq[code2bit(trans_sel)];
        m_wait = 1'b1; m_code = trans_sel; last_issue = c;
        if (trans_sel == 3'd2) n_sel2++;
      end

      chk("pend", pend, e_pend);
      chk("lt_done", lt_done, e_lt);
      chk("at_rsp_done", at_rsp_done, e_rsp);
      chk("at_cmd_done", at_cmd_done, e_cdone);
      chk("at_cmd_err", at_cmd_err, e_err);
      m_pend = e_pend;
      if (at_cmd_err) begin n_err++; err_at = c; end
      if (lt_done) n_lt_done++;
      if (at_cmd_done) n_cmd_done++;
    end
    p_rst = rst; p_lt = lt_req; p_rsp = at_rsp_req; p_cmd = at_cmd_req;
    p_rcvd = at_rsp_rcvd; p_sent = trans_sent; p_disc = disconnected_s;
  end

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic wait_issue(output int code);
    code = 0;
    for (int i = 0; i < 100; i++) begin
      if (trans_sel != 3'd0) begin
        code = trans_sel;
        break;
      end
      step();
    end
    chk("issue_seen_within_budget", (code != 0), 1);
  endtask

  task automatic serve(input int delay, output int code, output int sent_at);
    sent_at = -1;
    wait_issue(code);
    if (code != 0) begin
      repeat (delay) step();
      trans_sent = 1'b1;
      sent_at = cyc;
      step();
      trans_sent = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int code, c1, c2, c3, sent, t0, n0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // LT only: request at t0, select at t0+2, done the cycle after trans_sent
    t0 = cyc;
    lt_req = 1'b1; step(); lt_req = 1'b0;
    chk("lt_pend_set", pend, 3'b100);
    step();
    chk("lt_sel_at_n2", trans_sel, 4);
    step();
    chk("lt_sel_one_cycle", trans_sel, 0);
    while (cyc < t0 + 30) step();
    trans_sent = 1'b1; step(); trans_sent = 1'b0;
    chk("lt_done_at_m1", lt_done, 1);
    step();
    chk("lt_done_single_pulse", lt_done, 0);
    repeat (8) step();

    // Simultaneous requests: strict priority order
    lt_req = 1'b1; at_rsp_req = 1'b1; at_cmd_req = 1'b1;
    step();
    lt_req = 1'b0; at_rsp_req = 1'b0; at_cmd_req = 1'b0;
    chk("all_pend_set", pend, 3'b111);
    serve(3, c1, sent);
    serve(3, c2, sent);
    serve(3, c3, sent);
    chk("order_first_lt", c1, 4);
    chk("order_second_at_rsp", c2, 3);
    chk("order_third_at_cmd", c3, 2);

    // AT command answered 10 cycles after it was sent
    repeat (4) step();
    chk("busy_while_outstanding", busy, 1);
    repeat (5) step();
    at_rsp_rcvd = 1'b1; step(); at_rsp_rcvd = 1'b0;
    chk("cmd_done_after_rsp", at_cmd_done, 1);
    chk("no_err_with_rsp", at_cmd_err, 0);
    repeat (30) step();
    chk("no_err_later", n_err, 0);

    // No response: timeout, optional retries, then a single error
    n0 = n_sel2;
    at_cmd_req = 1'b1; step(); at_cmd_req = 1'b0;
    for (int k = 0; k < CMD_ISSUES; k++) begin
      serve(2, code, sent);
      chk("timeout_issue_code", code, 2);
    end
    for (int i = 0; i < 40 && n_err == 0; i++) step();
    chk("err_count", n_err, 1);
    chk("err_time", err_at, sent + T + 1);
    repeat (40) step();
    chk("cmd_issue_count", n_sel2 - n0, CMD_ISSUES);
    chk("err_single", n_err, 1);

    // Disconnect while waiting for trans_sent
    n0 = n_lt_done;
    lt_req = 1'b1; step(); lt_req = 1'b0;
    wait_issue(code);
    chk("disc_first_code", code, 4);
    step(); step();
    disconnected_s = 1'b1; step();
    chk("disc_pend_reset", pend, 3'b100);
    step();
    disconnected_s = 1'b0;
    chk("disc_no_lt_done", n_lt_done - n0, 0);
    serve(2, code, sent);
    chk("reissue_code", code, 4);
    step();
    chk("reissue_lt_done", n_lt_done - n0, 1);

    repeat (10) step();
    chk("end_busy", busy, 0);
    chk("end_pend", pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
